// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared types for the memory bus arbiter: FSM state encoding, bus owner,
//   the bus request payload struct and a helper that builds a fetch payload.
//   The payload field widths are the bus widths; the arbiter top defaults
//   its ADDR_W/DATA_W parameters to these values and they must stay equal.
package mem_bus_arbiter_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  // Instruction fetches are always whole-word reads.
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    I_ADDR,
    I_DATA,
    D_ADDR,
    D_DATA
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE,
    I,
    D
  } owner_t;

  typedef struct packed {
    logic                  wr;
    logic [1:0]            size;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } bus_req_t;

  function automatic bus_req_t fetch_req(input logic [BUS_ADDR_W-1:0] addr);
    bus_req_t r;
    r.wr    = 1'b0;
    r.size  = SIZE_WORD;
    r.addr  = addr;
    r.wdata = '0;
    return r;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   SRAM-like memory bus between the arbiter (master) and the memory (slave).
//   Request side : bus_req, bus_wr, bus_size, bus_addr, bus_wdata (master out)
//   Response side: bus_addr_ok, bus_data_ok, bus_rdata            (slave out)
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              bus_req;
  logic              bus_wr;
  logic [1:0]        bus_size;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );

endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one SRAM-like memory bus between the fetch stage (i_*) and the
//   memory stage (d_*). One transaction outstanding at a time; data requests
//   beat instruction requests. Cancelled fetches complete on the bus but
//   their completion pulse is swallowed. Also produces the stall requests.
// Ports
//   clk, resetn       : clock, asynchronous active-low reset
//   i_req/i_addr      : fetch request (level) and address
//   i_cancel          : drop the in-flight fetch result
//   i_rdata/i_data_ok : fetch read data and completion pulse
//   d_req/d_wr/d_size/d_addr/d_wdata : data request and payload
//   d_rdata/d_data_ok : data read data and completion pulse
//   bus               : memory bus, master side
//   stall_i, stall_d  : stall requests to the hazard unit
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_cancel,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_data_ok,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_data_ok,
  mem_bus_arbiter_if.master bus,
  output logic              stall_i,
  output logic              stall_d
);

  arb_state_t r_state, w_state_next;
  owner_t     r_owner, w_owner_next;
  logic       r_discard, w_discard_next;
  bus_req_t   r_payload, w_payload_next;

  bus_req_t   w_d_payload;
  bus_req_t   w_i_payload;
  bus_req_t   w_bus_payload;
  logic       w_bus_req;
  logic       w_i_ok;
  logic       w_d_ok;
  logic       w_run;

  assign w_d_payload = '{wr: d_wr, size: d_size, addr: d_addr, wdata: d_wdata};
  assign w_i_payload = fetch_req(i_addr);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_owner   <= NONE;
      r_discard <= 1'b0;
      r_payload <= '0;
    end else begin
      r_state   <= w_state_next;
      r_owner   <= w_owner_next;
      r_discard <= w_discard_next;
      r_payload <= w_payload_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and bus/completion outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_owner_next   = r_owner;
    w_discard_next = r_discard;
    w_payload_next = r_payload;
    w_bus_req      = 1'b0;
    w_bus_payload  = '0;
    w_i_ok         = 1'b0;
    w_d_ok         = 1'b0;

    unique case (r_state)
      IDLE: begin
        // The granted client drives the bus straight from its inputs so an
        // immediate addr_ok costs no extra cycle; the latch covers the wait.
        if (d_req) begin
          w_bus_req      = 1'b1;
          w_bus_payload  = w_d_payload;
          w_payload_next = w_d_payload;
          w_owner_next   = D;
          w_state_next   = bus.bus_addr_ok ? D_DATA : D_ADDR;
        end else if (i_req) begin
          w_bus_req      = 1'b1;
          w_bus_payload  = w_i_payload;
          w_payload_next = w_i_payload;
          w_owner_next   = I;
          w_state_next   = bus.bus_addr_ok ? I_DATA : I_ADDR;
        end else begin
          w_owner_next   = NONE;
        end
      end

      I_ADDR, D_ADDR: begin
        // Latched payload keeps the bus stable even if the client misbehaves.
        // data_ok is not legal before acceptance and is ignored here.
        w_bus_req     = 1'b1;
        w_bus_payload = r_payload;
        if (bus.bus_addr_ok) begin
          w_state_next = (r_state == I_ADDR) ? I_DATA : D_DATA;
        end
      end

      I_DATA: begin
        if (bus.bus_data_ok) begin
          // A cancel in the completing cycle also swallows the pulse.
          w_i_ok       = ~r_discard & ~i_cancel;
          w_state_next = IDLE;
          w_owner_next = NONE;
        end
      end

      D_DATA: begin
        if (bus.bus_data_ok) begin
          w_d_ok       = 1'b1;
          w_state_next = IDLE;
          w_owner_next = NONE;
        end
      end

      default: begin
        w_state_next = IDLE;
        w_owner_next = NONE;
      end
    endcase

    // Discard tracks a cancelled fetch until its bus transaction retires.
    if ((r_owner == I) && i_cancel) begin
      w_discard_next = 1'b1;
    end
    if ((r_state == I_DATA) && bus.bus_data_ok) begin
      w_discard_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. IDLE paths are combinational from client inputs, so every output
  // is additionally forced low while reset is held.
  // ---------------------------------------------------------------------------
  assign w_run = resetn;

  assign bus.bus_req   = w_run & w_bus_req;
  assign bus.bus_wr    = w_run & w_bus_payload.wr;
  assign bus.bus_size  = w_run ? w_bus_payload.size  : 2'b00;
  assign bus.bus_addr  = w_run ? w_bus_payload.addr  : '0;
  assign bus.bus_wdata = w_run ? w_bus_payload.wdata : '0;

  assign i_data_ok = w_run & w_i_ok;
  assign d_data_ok = w_run & w_d_ok;
  assign i_rdata   = i_data_ok ? bus.bus_rdata : '0;
  assign d_rdata   = d_data_ok ? bus.bus_rdata : '0;

  assign stall_d = w_run & d_req & ~w_d_ok;
  assign stall_i = w_run & ((i_req & ~w_i_ok) | r_discard);

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single SRAM-like memory bus between the fetch stage (instruction reads) and the memory stage (data reads and writes). Requests are granted one at a time, with fixed data-over-instruction priority. Each client gets a completion pulse and a read-data path. The block produces the stall requests consumed by the hazard unit, and it discards fetches cancelled by branch or exception redirection.

Parameters:
ADDR_W, 32, address width for both clients and the bus
DATA_W, 32, data width for both clients and the bus

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
i_req  in  1  fetch request; level, held until i_data_ok
i_addr  in  ADDR_W  fetch address (word access, size fixed 2'b10)
i_cancel  in  1  pulse; in-flight fetch result must be dropped
i_rdata  out  DATA_W  fetch read data, valid with i_data_ok
i_data_ok  out  1  fetch completion pulse
d_req  in  1  data request; level, held until d_data_ok
d_wr  in  1  1 = write
d_size  in  2  0 = byte, 1 = half, 2 = word
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  data read data, valid with d_data_ok
d_data_ok  out  1  data completion pulse
bus_req  out  1  bus request
bus_wr  out  1  bus write
bus_size  out  2  bus size
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_addr_ok  in  1  address-phase accept
bus_data_ok  in  1  data-phase complete
bus_rdata  in  DATA_W  bus read data
stall_i  out  1  fetch must stall
stall_d  out  1  memory stage must stall

Behaviour:
- Reset: clk and resetn as named; reset is asynchronous and active-low. On reset, state=IDLE, owner=NONE, discard=0, and every output is 0.
- At most one transaction is outstanding. The FSM states are IDLE, I_ADDR, I_DATA, D_ADDR and D_DATA.
- IDLE, d_req=1:
  - Drive the bus combinationally from the d_* inputs (bus_req=1).
  - If bus_addr_ok, go to D_DATA; otherwise go to D_ADDR.
- IDLE, d_req=0 and i_req=1: same behaviour using i_* (wr=0, size=2'b10), going to I_DATA or I_ADDR.
- Priority: data always wins when both request in IDLE.
- x_ADDR:
  - Payload is latched at the IDLE grant; the bus is driven from the latch and never changes while bus_req=1.
  - Hold bus_req=1 until bus_addr_ok, then go to x_DATA.
  - bus_req is never withdrawn before acceptance.
- x_DATA: bus_req=0. When bus_data_ok arrives, pass bus_rdata and the pulse to the owner combinationally (x_data_ok=1 for exactly that cycle), then go to IDLE.
- Client re-requests are evaluated in IDLE on the cycle after completion, giving one turnaround cycle. Minimum latency is addr_ok in the request cycle and data_ok one cycle later.
- bus_addr_ok and bus_data_ok in the same cycle while in x_ADDR is illegal (protocol: data_ok follows acceptance). The arbiter ignores data_ok in x_ADDR.
- Client contract: payload is stable while req=1 and not yet completed. The client may drop or change req starting the cycle after x_data_ok.
- i_cancel:
  - If owner=I (I_ADDR or I_DATA), set discard=1. The transaction still completes on the bus, but i_data_ok is suppressed.
  - discard clears on that bus_data_ok.
  - A cancel arriving the same cycle as bus_data_ok suppresses that pulse.
  - A cancel with owner≠I, or in IDLE, has no effect.
- Stalls (combinational):
  - stall_d = d_req & ~d_data_ok.
  - stall_i = i_req & ~i_data_ok, or discard=1.
- i_rdata and d_rdata are 0 whenever the matching data_ok=0.
- resetn asserted mid-transaction: the FSM returns to IDLE immediately and the in-flight bus transaction is abandoned. The system bus is reset together with the core.

Decomposition:
- Shared package: arb_state_t enum (IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA), owner_t enum (NONE, I, D), and a bus_req_t struct (wr, size, addr, wdata) used for the latch and the mux.
- No sub-module: the FSM plus payload latch is a single module of roughly 150–200 lines.

Test Plan:
- i_req=1, addr=0xBFC00000; bus_addr_ok same cycle, bus_data_ok next cycle with rdata=0x3C080001 → i_data_ok pulse one cycle, i_rdata=0x3C080001, stall_i low in that cycle.
- i_req and d_req both rise in the same cycle (d: write, size=2, addr=0x80001000, wdata=0xDEADBEEF) → bus carries the data write first. After d_data_ok plus one IDLE cycle, the fetch is issued. stall_i stays high throughout.
- bus_addr_ok held low 3 cycles during a D read, with the d_addr input toggled → bus_req stays 1 and bus_addr stays at the latched value for all 4 cycles.
- i_cancel pulsed while in I_DATA, then bus_data_ok → i_data_ok stays 0 and stall_i stays high until completion. Next fetch issues normally.
- i_cancel in the same cycle as bus_data_ok → i_data_ok suppressed. With owner=D, i_cancel → d_data_ok unaffected.
- resetn pulsed low while in D_ADDR → all outputs 0 asynchronously, state=IDLE. After release, a pending d_req is granted on the next edge.
